// File: rtl/img_rsz_src_arb_if.sv
// Bus bundle between the pixel sources, the source arbiter and the image capturer.
// master: arbiter view (consumes source streams, drives the capturer side).
// slave : environment view (sources and capturer).
interface img_rsz_src_arb_if #(
    parameter int SRC_NUM            = 4,
    parameter int PXL_PRIM_COLOR_W   = 8,
    parameter int PXL_PRIM_COLOR_NUM = 3,
    parameter int IMG_WIDTH_IDX_W    = 11,
    parameter int IMG_HEIGHT_IDX_W   = 11
);
    localparam int PXL_W = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W;

    // source side
    logic [SRC_NUM*PXL_W-1:0]            SrcPxlData;
    logic [SRC_NUM*IMG_WIDTH_IDX_W-1:0]  SrcPxlX;
    logic [SRC_NUM*IMG_HEIGHT_IDX_W-1:0] SrcPxlY;
    logic [SRC_NUM*IMG_WIDTH_IDX_W-1:0]  SrcImgWidth;
    logic [SRC_NUM*IMG_HEIGHT_IDX_W-1:0] SrcImgHeight;
    logic [SRC_NUM-1:0]                  SrcPxlVld;
    logic [SRC_NUM-1:0]                  SrcPxlRdy;

    // capturer side
    logic [PXL_W-1:0]                    PxlData;
    logic [IMG_WIDTH_IDX_W-1:0]          PxlX;
    logic [IMG_HEIGHT_IDX_W-1:0]         PxlY;
    logic [IMG_WIDTH_IDX_W-1:0]          ImgWidth;
    logic [IMG_HEIGHT_IDX_W-1:0]         ImgHeight;
    logic                                PxlVld;
    logic                                PxlRdy;
    logic                                RszImgComp;

    modport master (
        input  SrcPxlData, SrcPxlX, SrcPxlY, SrcImgWidth, SrcImgHeight, SrcPxlVld,
        input  PxlRdy, RszImgComp,
        output SrcPxlRdy,
        output PxlData, PxlX, PxlY, ImgWidth, ImgHeight, PxlVld
    );

    modport slave (
        output SrcPxlData, SrcPxlX, SrcPxlY, SrcImgWidth, SrcImgHeight, SrcPxlVld,
        output PxlRdy, RszImgComp,
        input  SrcPxlRdy,
        input  PxlData, PxlX, PxlY, ImgWidth, ImgHeight, PxlVld
    );
endinterface

// File: rtl/img_rsz_src_arb.sv
// Frame-granular arbiter sharing one image-resizer pipeline between SRC_NUM sources.
// A source is granted for a whole frame; its stream is passed through combinationally
// and the grant is released only once the resizer reports completion.
// Build option: IMG_RSZ_ARB_FIXED_PRIO_EN selects lowest-index fixed priority
// instead of the default round-robin.
module img_rsz_src_arb #(
    parameter int SRC_NUM            = 4,
    parameter int PXL_PRIM_COLOR_W   = 8,
    parameter int PXL_PRIM_COLOR_NUM = 3,
    parameter int IMG_WIDTH_IDX_W    = 11,
    parameter int IMG_HEIGHT_IDX_W   = 11
) (
    input  logic                       Clk,
    input  logic                       Reset,
    img_rsz_src_arb_if.master          bus,
    output logic [$clog2(SRC_NUM)-1:0] FrmSrcId,
    output logic                       Busy,
    output logic                       ErrUnexpComp
);
    localparam int PXL_W = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W;
    localparam int ID_W  = $clog2(SRC_NUM);
    localparam int WW    = IMG_WIDTH_IDX_W;
    localparam int HW    = IMG_HEIGHT_IDX_W;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t          state, nextState;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] cand;
    logic            anyReq;
    logic [WW-1:0]   cntH;
    logic [HW-1:0]   cntV;
    logic            handshake, rowEnd, lastPxl;
`ifndef IMG_RSZ_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0] lastGrant;
`endif

    // per-source views of the flat buses
    logic [PXL_W-1:0] srcData   [SRC_NUM];
    logic [WW-1:0]    srcX      [SRC_NUM];
    logic [HW-1:0]    srcY      [SRC_NUM];
    logic [WW-1:0]    srcWidth  [SRC_NUM];
    logic [HW-1:0]    srcHeight [SRC_NUM];

    for (genvar s = 0; s < SRC_NUM; s++) begin : g_unpack
        assign srcData[s]   = bus.SrcPxlData[s*PXL_W +: PXL_W];
        assign srcX[s]      = bus.SrcPxlX[s*WW +: WW];
        assign srcY[s]      = bus.SrcPxlY[s*HW +: HW];
        assign srcWidth[s]  = bus.SrcImgWidth[s*WW +: WW];
        assign srcHeight[s] = bus.SrcImgHeight[s*HW +: HW];
    end

    // winner selection; the loop runs from far to near so the nearest requester wins
    always_comb begin
        winner = '0;
        cand   = '0;
        anyReq = |bus.SrcPxlVld;
        for (int unsigned i = SRC_NUM; i > 0; i--) begin
`ifdef IMG_RSZ_ARB_FIXED_PRIO_EN
            cand = ID_W'(i - 1);
`else
            cand = ID_W'((32'(lastGrant) + i) % SRC_NUM);
`endif
            if (bus.SrcPxlVld[cand]) winner = cand;
        end
    end

    assign handshake = (state == STREAM) && bus.PxlVld && bus.PxlRdy;
    assign rowEnd    = (cntH == bus.ImgWidth - WW'(1));
    assign lastPxl   = handshake && rowEnd && (cntV == bus.ImgHeight - HW'(1));

    // state register
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    // next-state logic; a completion pulse only counts in DRAIN
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (anyReq)         nextState = STREAM;
            STREAM:  if (lastPxl)        nextState = DRAIN;
            DRAIN:   if (bus.RszImgComp) nextState = IDLE;
            default:                     nextState = IDLE;
        endcase
    end

    // handshake routing: only the granted source is connected, and only in STREAM
    always_comb begin
        bus.PxlVld    = 1'b0;
        bus.SrcPxlRdy = '0;
        if (state == STREAM) begin
            bus.PxlVld              = bus.SrcPxlVld[FrmSrcId];
            bus.SrcPxlRdy[FrmSrcId] = bus.PxlRdy;
        end
    end

    assign bus.PxlData = srcData[FrmSrcId];
    assign bus.PxlX    = srcX[FrmSrcId];
    assign bus.PxlY    = srcY[FrmSrcId];
    assign Busy        = (state != IDLE);

    // grant capture, frame dimensions and raster counters
    always_ff @(posedge Clk) begin
        if (Reset) begin
            FrmSrcId      <= '0;
`ifndef IMG_RSZ_ARB_FIXED_PRIO_EN
            lastGrant     <= ID_W'(SRC_NUM - 1);
`endif
            bus.ImgWidth  <= '1;
            bus.ImgHeight <= '1;
            cntH          <= '0;
            cntV          <= '0;
        end else if (state == IDLE && anyReq) begin
            FrmSrcId      <= winner;
`ifndef IMG_RSZ_ARB_FIXED_PRIO_EN
            lastGrant     <= winner;
`endif
            bus.ImgWidth  <= srcWidth[winner];
            bus.ImgHeight <= srcHeight[winner];
            cntH          <= '0;
            cntV          <= '0;
        end else if (handshake) begin
            if (rowEnd) begin
                cntH <= '0;
                cntV <= cntV + HW'(1);
            end else begin
                cntH <= cntH + WW'(1);
            end
        end
    end

    // sticky flag for a completion pulse arriving outside DRAIN
    always_ff @(posedge Clk) begin
        if (Reset)                                  ErrUnexpComp <= 1'b0;
        else if (bus.RszImgComp && state != DRAIN)  ErrUnexpComp <= 1'b1;
    end
endmodule

// File: tb/tb_img_rsz_src_arb.sv
// Directed self-checking bench for img_rsz_src_arb.
// Grant order expectations follow IMG_RSZ_ARB_FIXED_PRIO_EN when it is defined.
module tb_img_rsz_src_arb;
    localparam int SRC_NUM = 4;
    localparam int CW      = 8;
    localparam int CN      = 3;
    localparam int WW      = 11;
    localparam int HW      = 11;
    localparam int PXL_W   = CN * CW;
    localparam int ID_W    = $clog2(SRC_NUM);

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic [ID_W-1:0] FrmSrcId;
    logic            Busy;
    logic            ErrUnexpComp;

    int passCnt  = 0;
    int totalCnt = 0;

    img_rsz_src_arb_if #(
        .SRC_NUM(SRC_NUM), .PXL_PRIM_COLOR_W(CW), .PXL_PRIM_COLOR_NUM(CN),
        .IMG_WIDTH_IDX_W(WW), .IMG_HEIGHT_IDX_W(HW)
    ) bus ();

    img_rsz_src_arb #(
        .SRC_NUM(SRC_NUM), .PXL_PRIM_COLOR_W(CW), .PXL_PRIM_COLOR_NUM(CN),
        .IMG_WIDTH_IDX_W(WW), .IMG_HEIGHT_IDX_W(HW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus.master),
        .FrmSrcId(FrmSrcId), .Busy(Busy), .ErrUnexpComp(ErrUnexpComp)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [PXL_W-1:0] pxlOf(input int s);
        return PXL_W'(32'hA50000 + s * 32'h111);
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic setSrc(input int s, input logic v, input int w, input int h);
        bus.SrcPxlVld[s]             = v;
        bus.SrcImgWidth[s*WW +: WW]  = WW'(w);
        bus.SrcImgHeight[s*HW +: HW] = HW'(h);
    endtask

    task automatic initSrcs;
        for (int s = 0; s < SRC_NUM; s++) begin
            bus.SrcPxlData[s*PXL_W +: PXL_W] = pxlOf(s);
            bus.SrcPxlX[s*WW +: WW]          = WW'(s + 1);
            bus.SrcPxlY[s*HW +: HW]          = HW'(s + 2);
            setSrc(s, 1'b0, 1, 1);
        end
        bus.PxlRdy     = 1'b0;
        bus.RszImgComp = 1'b0;
    endtask

    task automatic doReset;
        Reset          = 1'b1;
        bus.SrcPxlVld  = '0;
        bus.PxlRdy     = 1'b0;
        bus.RszImgComp = 1'b0;
        tick;
        tick;
        Reset = 1'b0;
    endtask

    // observes one frame from IDLE to DRAIN, then issues the completion pulse
    task automatic runFrame(input int nPix, output int gotSrc, output int hs,
                            output int leak, output int dataErr, output bit drainOk);
        hs = 0; leak = 0; dataErr = 0; gotSrc = -1; drainOk = 1'b0;
        for (int c = 0; c < nPix + 10 && hs < nPix; c++) begin
            tick;
            if (Busy) gotSrc = int'(FrmSrcId);
            if ((bus.SrcPxlRdy & ~(SRC_NUM'(1) << FrmSrcId)) != '0) leak++;
            if (bus.PxlVld && bus.PxlRdy) begin
                hs++;
                if (bus.PxlData !== pxlOf(int'(FrmSrcId))) dataErr++;
            end
        end
        tick;
        drainOk = Busy && !bus.PxlVld && (bus.SrcPxlRdy == '0);
        bus.RszImgComp = 1'b1;
        tick;
        bus.RszImgComp = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        setSrc(0, 1'b1, 4, 2);
        bus.PxlRdy = 1'b1;
        tick;
        tick;
        totalCnt++; if (Busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", Busy); else passCnt++;
        totalCnt++; if (bus.PxlVld !== 1'b0) $display("FAIL reset_pxlvld got=%0b exp=0", bus.PxlVld); else passCnt++;
        totalCnt++; if (bus.SrcPxlRdy !== 4'b0000) $display("FAIL reset_srcrdy got=%b exp=0000", bus.SrcPxlRdy); else passCnt++;
        totalCnt++; if (bus.ImgWidth !== 11'h7FF) $display("FAIL reset_width got=%h exp=7ff", bus.ImgWidth); else passCnt++;
        totalCnt++; if (bus.ImgHeight !== 11'h7FF) $display("FAIL reset_height got=%h exp=7ff", bus.ImgHeight); else passCnt++;
        totalCnt++; if (FrmSrcId !== 2'd0) $display("FAIL reset_srcid got=%0d exp=0", FrmSrcId); else passCnt++;
        totalCnt++; if (ErrUnexpComp !== 1'b0) $display("FAIL reset_err got=%0b exp=0", ErrUnexpComp); else passCnt++;
        doReset;
    endtask

    task automatic test_single;
        int hs = 0, first = 0, last = 0, drainCyc = 0, dataErr = 0;
        logic [WW-1:0] firstX = '0;
        doReset;
        setSrc(0, 1'b1, 4, 2);
        bus.PxlRdy = 1'b1;
        #1;
        totalCnt++; if (bus.SrcPxlRdy !== 4'b0000 || bus.PxlVld !== 1'b0)
            $display("FAIL single_idle_norx got rdy=%b vld=%0b exp rdy=0000 vld=0", bus.SrcPxlRdy, bus.PxlVld); else passCnt++;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick;
            if (bus.PxlVld && bus.PxlRdy) begin
                hs++;
                if (first == 0) begin first = cyc; firstX = bus.PxlX; end
                last = cyc;
                if (bus.PxlData !== pxlOf(0)) dataErr++;
            end
            if (Busy && !bus.PxlVld && hs > 0) begin drainCyc = cyc; break; end
        end
        totalCnt++; if (hs !== 8) $display("FAIL single_hs_count got=%0d exp=8", hs); else passCnt++;
        totalCnt++; if (first !== 1) $display("FAIL single_first_cycle got=%0d exp=1", first); else passCnt++;
        totalCnt++; if (last !== 8) $display("FAIL single_last_cycle got=%0d exp=8", last); else passCnt++;
        totalCnt++; if (drainCyc !== 9) $display("FAIL single_drain_cycle got=%0d exp=9", drainCyc); else passCnt++;
        totalCnt++; if (dataErr !== 0) $display("FAIL single_data got=%0d bad exp=0", dataErr); else passCnt++;
        totalCnt++; if (firstX !== 11'd1) $display("FAIL single_pxlx got=%0d exp=1", firstX); else passCnt++;
        totalCnt++; if (bus.ImgWidth !== 11'd4 || bus.ImgHeight !== 11'd2)
            $display("FAIL single_dims got=%0dx%0d exp=4x2", bus.ImgWidth, bus.ImgHeight); else passCnt++;
        totalCnt++; if (FrmSrcId !== 2'd0) $display("FAIL single_srcid got=%0d exp=0", FrmSrcId); else passCnt++;
        bus.SrcPxlVld  = '0;
        bus.RszImgComp = 1'b1;
        tick;
        bus.RszImgComp = 1'b0;
        #1;
        totalCnt++; if (Busy !== 1'b0) $display("FAIL single_idle_after_comp got=%0b exp=0", Busy); else passCnt++;
        totalCnt++; if (ErrUnexpComp !== 1'b0) $display("FAIL single_err got=%0b exp=0", ErrUnexpComp); else passCnt++;
    endtask

    task automatic test_arbitration;
        int expSrc [4];
        int gotSrc, hs, leak, dataErr;
        bit drainOk;
`ifdef IMG_RSZ_ARB_FIXED_PRIO_EN
        expSrc = '{0, 0, 0, 0};
`else
        expSrc = '{0, 2, 0, 2};
`endif
        doReset;
        setSrc(0, 1'b1, 2, 2);
        setSrc(2, 1'b1, 2, 2);
        bus.PxlRdy = 1'b1;
        for (int f = 0; f < 4; f++) begin
            runFrame(4, gotSrc, hs, leak, dataErr, drainOk);
            totalCnt++; if (gotSrc !== expSrc[f]) $display("FAIL arb_grant[%0d] got=%0d exp=%0d", f, gotSrc, expSrc[f]); else passCnt++;
            totalCnt++; if (hs !== 4) $display("FAIL arb_hs[%0d] got=%0d exp=4", f, hs); else passCnt++;
            totalCnt++; if (leak !== 0) $display("FAIL arb_rdy_leak[%0d] got=%0d exp=0", f, leak); else passCnt++;
            totalCnt++; if (dataErr !== 0) $display("FAIL arb_data[%0d] got=%0d bad exp=0", f, dataErr); else passCnt++;
            totalCnt++; if (drainOk !== 1'b1) $display("FAIL arb_drain[%0d] got=%0b exp=1", f, drainOk); else passCnt++;
        end
        bus.SrcPxlVld = '0;
    endtask

    task automatic test_stall;
        int hs = 0, streamErr = 0, lastHsCyc = -1, extra = 0;
        logic v, r;
        doReset;
        setSrc(1, 1'b1, 3, 3);
        bus.PxlRdy = 1'b1;
        tick;
        for (int c = 0; c < 60 && hs < 9; c++) begin
            v = (c % 6) != 4;
            r = (c % 2) == 0;
            bus.SrcPxlVld[1] = v;
            bus.PxlRdy       = r;
            #1;
            if (!Busy || bus.PxlVld !== v || bus.SrcPxlRdy !== (SRC_NUM'(r) << 1)) streamErr++;
            if (bus.PxlVld && bus.PxlRdy) begin hs++; lastHsCyc = c; end
            tick;
        end
        bus.SrcPxlVld[1] = 1'b1;
        bus.PxlRdy       = 1'b1;
        #1;
        totalCnt++; if (hs !== 9) $display("FAIL stall_hs_count got=%0d exp=9", hs); else passCnt++;
        totalCnt++; if (lastHsCyc !== 24) $display("FAIL stall_last_cycle got=%0d exp=24", lastHsCyc); else passCnt++;
        totalCnt++; if (streamErr !== 0) $display("FAIL stall_passthru got=%0d bad exp=0", streamErr); else passCnt++;
        totalCnt++; if (Busy !== 1'b1 || bus.PxlVld !== 1'b0)
            $display("FAIL stall_drain got busy=%0b vld=%0b exp busy=1 vld=0", Busy, bus.PxlVld); else passCnt++;
        totalCnt++; if (FrmSrcId !== 2'd1) $display("FAIL stall_srcid got=%0d exp=1", FrmSrcId); else passCnt++;
        totalCnt++; if (bus.ImgWidth !== 11'd3) $display("FAIL stall_width got=%0d exp=3", bus.ImgWidth); else passCnt++;
        for (int k = 0; k < 3; k++) begin
            tick;
            if (bus.PxlVld && bus.PxlRdy) extra++;
        end
        totalCnt++; if (extra !== 0) $display("FAIL stall_extra_hs got=%0d exp=0", extra); else passCnt++;
        bus.SrcPxlVld = '0;
    endtask

    task automatic test_comp_err;
        doReset;
        bus.RszImgComp = 1'b1;
        tick;
        bus.RszImgComp = 1'b0;
        #1;
        totalCnt++; if (Busy !== 1'b0) $display("FAIL comp_idle_state got busy=%0b exp=0", Busy); else passCnt++;
        totalCnt++; if (ErrUnexpComp !== 1'b1) $display("FAIL comp_idle_err got=%0b exp=1", ErrUnexpComp); else passCnt++;
        setSrc(0, 1'b1, 4, 2);
        bus.PxlRdy = 1'b1;
        tick;
        bus.RszImgComp = 1'b1;
        tick;
        bus.RszImgComp = 1'b0;
        #1;
        totalCnt++; if (Busy !== 1'b1 || bus.PxlVld !== 1'b1)
            $display("FAIL comp_stream_state got busy=%0b vld=%0b exp busy=1 vld=1", Busy, bus.PxlVld); else passCnt++;
        repeat (6) tick;
        totalCnt++; if (bus.PxlVld !== 1'b1) $display("FAIL comp_before_last got vld=%0b exp=1", bus.PxlVld); else passCnt++;
        bus.RszImgComp = 1'b1;
        tick;
        bus.RszImgComp = 1'b0;
        #1;
        totalCnt++; if (Busy !== 1'b1 || bus.PxlVld !== 1'b0)
            $display("FAIL comp_last_same_cycle got busy=%0b vld=%0b exp busy=1 vld=0", Busy, bus.PxlVld); else passCnt++;
        tick;
        totalCnt++; if (Busy !== 1'b1) $display("FAIL comp_not_consumed got busy=%0b exp=1", Busy); else passCnt++;
        bus.SrcPxlVld  = '0;
        bus.RszImgComp = 1'b1;
        tick;
        bus.RszImgComp = 1'b0;
        #1;
        totalCnt++; if (Busy !== 1'b0) $display("FAIL comp_drain_exit got busy=%0b exp=0", Busy); else passCnt++;
        totalCnt++; if (ErrUnexpComp !== 1'b1) $display("FAIL comp_err_sticky got=%0b exp=1", ErrUnexpComp); else passCnt++;
    endtask

    task automatic test_reset_mid;
        doReset;
        bus.RszImgComp = 1'b1;
        tick;
        bus.RszImgComp = 1'b0;
        setSrc(0, 1'b1, 4, 2);
        setSrc(1, 1'b1, 4, 2);
        bus.PxlRdy = 1'b1;
        tick;
        totalCnt++; if (FrmSrcId !== 2'd0) $display("FAIL rstmid_first_grant got=%0d exp=0", FrmSrcId); else passCnt++;
        repeat (4) tick;
        totalCnt++; if (ErrUnexpComp !== 1'b1 || bus.PxlVld !== 1'b1)
            $display("FAIL rstmid_pre got err=%0b vld=%0b exp err=1 vld=1", ErrUnexpComp, bus.PxlVld); else passCnt++;
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        #1;
        totalCnt++; if (Busy !== 1'b0 || bus.PxlVld !== 1'b0)
            $display("FAIL rstmid_idle got busy=%0b vld=%0b exp busy=0 vld=0", Busy, bus.PxlVld); else passCnt++;
        totalCnt++; if (bus.SrcPxlRdy !== 4'b0000) $display("FAIL rstmid_srcrdy got=%b exp=0000", bus.SrcPxlRdy); else passCnt++;
        totalCnt++; if (bus.ImgWidth !== 11'h7FF) $display("FAIL rstmid_width got=%h exp=7ff", bus.ImgWidth); else passCnt++;
        totalCnt++; if (ErrUnexpComp !== 1'b0) $display("FAIL rstmid_err got=%0b exp=0", ErrUnexpComp); else passCnt++;
        tick;
        totalCnt++; if (Busy !== 1'b1 || FrmSrcId !== 2'd0)
            $display("FAIL rstmid_regrant got busy=%0b id=%0d exp busy=1 id=0", Busy, FrmSrcId); else passCnt++;
        doReset;
    endtask

    initial begin
        initSrcs;
        test_reset;
        test_single;
        test_arbitration;
        test_stall;
        test_comp_err;
        test_reset_mid;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
